// File: rtl/i_ref_dac_spi.sv
// rtl/i_ref_dac_spi.sv - serial DAC writer for the control loop current reference
module i_ref_dac_spi #(
  parameter int         BUS_WIDTH = 10,
  parameter logic [3:0] CMD       = 4'b0011,
  parameter int         CLK_DIV   = 4,
  parameter int         CS_HIGH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] i_ref_in,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] i_ref_sent
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int HW = $clog2(CS_HIGH) + 1;
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(CS_HIGH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    TAIL,
    HOLD
  } state_t;

  state_t               state;
  logic [DW-1:0]        div_cnt;
  logic [HW-1:0]        hold_cnt;
  logic [3:0]           bit_cnt;
  logic [14:0]          frame_sr;
  logic [BUS_WIDTH-1:0] latched;
  logic                 pending;

  logic [11:0]          ref_just;
  logic [15:0]          next_frame;
  logic                 start_ok;
  logic                 start_now;

  // Build the outgoing frame and decide whether a new frame may begin; the end
  // of HOLD counts as an idle slot so back-to-back frames lose no cycle.
  always_comb begin
    ref_just   = 12'(i_ref_in) << (12 - BUS_WIDTH);
    next_frame = {CMD, ref_just};
    start_ok   = enable && (pending || (i_ref_in != i_ref_sent));
    start_now  = start_ok && ((state == IDLE) || ((state == HOLD) && (hold_cnt == '0)));
  end

  // Frame sequencer: SETUP, 16 sclk periods, trailing low phase, then cs_n high time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      hold_cnt   <= '0;
      bit_cnt    <= '0;
      frame_sr   <= '0;
      latched    <= '0;
      pending    <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      i_ref_sent <= '0;
    end else begin
      done <= 1'b0;
      if (start_now) begin
        state    <= SETUP;
        pending  <= 1'b0;
        latched  <= i_ref_in;
        frame_sr <= next_frame[14:0];
        mosi     <= next_frame[15];
        cs_n     <= 1'b0;
        busy     <= 1'b1;
        div_cnt  <= DIV_LOAD;
        bit_cnt  <= 4'd15;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          SETUP: begin
            if (div_cnt == '0) begin
              sclk    <= 1'b1;
              div_cnt <= DIV_LOAD;
              state   <= SHIFT;
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          SHIFT: begin
            if (div_cnt == '0) begin
              div_cnt <= DIV_LOAD;
              if (sclk) begin
                sclk <= 1'b0;
                if (bit_cnt == 4'd0) begin
                  state <= TAIL;
                end else begin
                  mosi     <= frame_sr[14];
                  frame_sr <= {frame_sr[13:0], 1'b0};
                  bit_cnt  <= bit_cnt - 1'b1;
                end
              end else begin
                sclk <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          TAIL: begin
            if (div_cnt == '0) begin
              state      <= HOLD;
              cs_n       <= 1'b1;
              mosi       <= 1'b0;
              done       <= 1'b1;
              i_ref_sent <= latched;
              hold_cnt   <= HOLD_LOAD;
            end else begin
              div_cnt <= div_cnt - 1'b1;
            end
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i_ref_dac_spi.sv
// tb/tb_i_ref_dac_spi.sv - scoreboard bench for i_ref_dac_spi
module tb_i_ref_dac_spi;

  localparam int BW  = 10;
  localparam int T   = 4;
  localparam int CSH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable;
  logic [BW-1:0] ref_in;
  logic          sclk, mosi, cs_n, busy, done;
  logic [BW-1:0] i_ref_sent;

  logic          rst2_n, en2;
  logic [11:0]   ref2;
  logic          sclk2, mosi2, cs2, busy2, done2;
  logic [11:0]   sent2;

  i_ref_dac_spi #(.BUS_WIDTH(BW), .CMD(4'b0011), .CLK_DIV(T), .CS_HIGH(CSH)) dut (
    .clk(clk), .rst(rst_n), .enable(enable), .i_ref_in(ref_in),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done), .i_ref_sent(i_ref_sent)
  );

  i_ref_dac_spi #(.BUS_WIDTH(12), .CMD(4'b0011), .CLK_DIV(1), .CS_HIGH(1)) dut_min (
    .clk(clk), .rst(rst2_n), .enable(en2), .i_ref_in(ref2),
    .sclk(sclk2), .mosi(mosi2), .cs_n(cs2), .busy(busy2), .done(done2), .i_ref_sent(sent2)
  );

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  int exp2_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame: command 3 in the top nibble, value left-justified in 12 bits.
  function automatic logic [31:0] model_frame(input int val, input int bw);
    int f;
    f = 'h3000 + val * (1 << (12 - bw));
    return 32'(f);
  endfunction

  // Main DUT monitor: protocol checks plus scoreboard pop on every done.
  int          cyc = 0;
  int          fall_cyc = 0;
  int          falls = 0;
  int          edges = 0;
  logic [15:0] sr = '0;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;

  always @(negedge clk) begin
    int v;
    cyc++;
    if (rst_n) begin
      if (p_cs && !cs_n) begin
        fall_cyc = cyc;
        edges    = 0;
        falls++;
      end
      if (cs_n) begin
        check("sclk_idle_low", sclk, 0);
        check("mosi_idle_low", mosi, 0);
      end
      if (!p_sclk && sclk) begin
        edges++;
        sr = {sr[14:0], mosi};
        check("mosi_stable_at_rise", mosi, p_mosi);
        check("cs_low_at_rise", cs_n, 0);
      end
      if (done) begin
        check("done_cs_high", cs_n, 1);
        check("edges_per_frame", edges, 16);
        check("done_latency", cyc - fall_cyc, 33 * T);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame actual=%0h required=none", sr);
        end else begin
          v = exp_q.pop_front();
          check("frame", sr, model_frame(v, BW));
          check("i_ref_sent", i_ref_sent, v);
        end
      end
    end
    p_sclk = sclk;
    p_cs   = cs_n;
    p_mosi = mosi;
  end

  // Minimum-divider DUT monitor.
  int          cyc2 = 0;
  int          fall2_cyc = 0;
  int          e2 = 0;
  int          falls2[$];
  logic [15:0] sr2 = '0;
  logic        p2_sclk = 1'b0, p2_cs = 1'b1;

  always @(negedge clk) begin
    int v;
    cyc2++;
    if (rst2_n) begin
      if (p2_cs && !cs2) begin
        fall2_cyc = cyc2;
        e2        = 0;
        falls2.push_back(cyc2);
      end
      if (!p2_sclk && sclk2) begin
        e2++;
        sr2 = {sr2[14:0], mosi2};
      end
      if (done2) begin
        check("min_edges", e2, 16);
        check("min_done_latency", cyc2 - fall2_cyc, 33);
        if (exp2_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL min_unexpected_frame actual=%0h required=none", sr2);
        end else begin
          v = exp2_q.pop_front();
          check("min_frame", sr2, model_frame(v, 12));
          check("min_i_ref_sent", sent2, v);
        end
      end
    end
    p2_sclk = sclk2;
    p2_cs   = cs2;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    #1;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic wait_edges(input int target);
    int n = 0;
    repeat (2) @(negedge clk);
    #1;
    while (edges < target && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (edges < target) begin
      total++;
      bad++;
      $display("FAIL edge_timeout actual=%0d required=%0d", edges, target);
    end
  endtask

  initial begin
    int sent, a, b, c, v, base, mode, n;
    rst_n  = 1'b0;
    enable = 1'b0;
    ref_in = '0;
    rst2_n = 1'b0;
    en2    = 1'b0;
    ref2   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_i_ref_sent", i_ref_sent, 0);

    // Power-up frame
    enable = 1'b1;
    ref_in = 10'h200;
    exp_q.push_back('h200);
    sent = 'h200;
    rst_n = 1'b1;
    wait_idle(600);
    base = falls;
    repeat (300) @(negedge clk);
    #1;
    check("no_repeat_frame", falls - base, 0);

    // Change coalescing
    ref_in = 10'h100;
    exp_q.push_back('h100);
    repeat (20) @(negedge clk);
    #1;
    ref_in = 10'h101;
    repeat (20) @(negedge clk);
    #1;
    ref_in = 10'h102;
    exp_q.push_back('h102);
    sent = 'h102;
    wait_idle(800);

    // Enable gating
    ref_in = 10'h155;
    exp_q.push_back('h155);
    wait_edges(8);
    enable = 1'b0;
    ref_in = 10'h2AA;
    wait_idle(800);
    sent = 'h155;
    base = falls;
    repeat (200) @(negedge clk);
    #1;
    check("gated_no_start", falls - base, 0);
    check("gated_busy", busy, 0);
    enable = 1'b1;
    exp_q.push_back('h2AA);
    sent = 'h2AA;
    wait_idle(800);

    // Reset mid-frame
    ref_in = 10'h0F3;
    wait_edges(11);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sent", i_ref_sent, 0);
    check("midrst_mosi", mosi, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('h0F3);
    sent = 'h0F3;
    wait_idle(800);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        v = $urandom_range(0, 1023);
        if (v != sent) exp_q.push_back(v);
        sent = v;
        ref_in = BW'(v);
        wait_idle(800);
      end else if (mode == 1) begin
        a = $urandom_range(0, 1023);
        if (a == sent) a = (a + 1) % 1024;
        exp_q.push_back(a);
        ref_in = BW'(a);
        n = $urandom_range(10, 90);
        repeat (n) @(negedge clk);
        #1;
        b = $urandom_range(0, 1023);
        ref_in = BW'(b);
        n = $urandom_range(1, 20);
        repeat (n) @(negedge clk);
        #1;
        c = $urandom_range(0, 1023);
        ref_in = BW'(c);
        if (c != a) exp_q.push_back(c);
        sent = c;
        wait_idle(1000);
      end else begin
        enable = 1'b0;
        v = $urandom_range(0, 1023);
        ref_in = BW'(v);
        base = falls;
        repeat (50) @(negedge clk);
        #1;
        check("rand_gated_no_start", falls - base, 0);
        enable = 1'b1;
        if (v != sent) exp_q.push_back(v);
        sent = v;
        wait_idle(800);
      end
    end

    // Minimum divider, back-to-back frames
    en2  = 1'b1;
    ref2 = 12'hFFF;
    exp2_q.push_back('hFFF);
    rst2_n = 1'b1;
    n = 0;
    while (falls2.size() < 1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    ref2 = 12'hABC;
    exp2_q.push_back('hABC);
    n = 0;
    while ((exp2_q.size() != 0 || busy2) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 300 || falls2.size() < 2) begin
      total++;
      bad++;
      $display("FAIL min_timeout actual=%0d required=2", falls2.size());
    end else begin
      check("min_back_to_back", falls2[1] - falls2[0], 34);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
